// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state type, default geometry and buffer-select helper
// for the Sobel line-buffer controller and its window mux.
package sobel_pkg;

   localparam int DEF_LINE_W = 128;
   localparam int DEF_NUM_LB = 4;
   localparam int DEF_PIX_W  = 8;
   localparam int LB_SEL_W   = $clog2(DEF_NUM_LB);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_LINE = 1'b1
   } lb_state_e;

   // Advance a line-buffer index, wrapping from the last buffer back to 0.
   function automatic logic [LB_SEL_W-1:0] lb_inc(input logic [LB_SEL_W-1:0] sel);
      logic [LB_SEL_W-1:0] nxt;
      if (sel == LB_SEL_W'(DEF_NUM_LB - 1)) begin
         nxt = '0;
      end else begin
         nxt = sel + LB_SEL_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sobel_lb_win_mux.sv
// sobel_lb_win_mux: picks the three line-buffer windows that form the current
// 3x3 window, starting at rd_sel (oldest line) and rotating through the ring.
module sobel_lb_win_mux
   import sobel_pkg::*;
#(
   parameter int NUM_LB = DEF_NUM_LB,
   parameter int PIX_W  = DEF_PIX_W
) (
   input  logic [NUM_LB*3*PIX_W-1:0] lb_rd_data,
   input  logic [LB_SEL_W-1:0]       rd_sel,
   output logic [9*PIX_W-1:0]        win_data
);

   localparam int ROW_W = 3 * PIX_W;

   logic [ROW_W-1:0] rows [NUM_LB];

   for (genvar g = 0; g < NUM_LB; g++) begin : g_row
      assign rows[g] = lb_rd_data[g*ROW_W +: ROW_W];
   end

   // Oldest line (rd_sel) goes to the MSBs, the newest of the three to the LSBs.
   always_comb begin
      win_data = {rows[rd_sel], rows[lb_inc(rd_sel)], rows[lb_inc(lb_inc(rd_sel))]};
   end

endmodule

// File: rtl/sobel_lb_ctrl.sv
// sobel_lb_ctrl: sequencer for four round-robin line buffers feeding the Sobel
// stage. Writes pixels into one buffer at a time; once three lines are held it
// streams one line of 3x3 windows, then retires the oldest line.
// Optional feature: define SOBEL_LB_CTRL_OVF_EN to add the sticky ovf_err output.
module sobel_lb_ctrl
   import sobel_pkg::*;
#(
   parameter int LINE_W = DEF_LINE_W,
   parameter int NUM_LB = DEF_NUM_LB,
   parameter int PIX_W  = DEF_PIX_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      pix_valid,
   input  logic [PIX_W-1:0]          pix_data,
   output logic                      pix_ready,
   output logic [NUM_LB-1:0]         lb_wr_en,
   output logic [PIX_W-1:0]          lb_wr_data,
   output logic [NUM_LB-1:0]         lb_rd_en,
   input  logic [NUM_LB*3*PIX_W-1:0] lb_rd_data,
   output logic [9*PIX_W-1:0]        win_data,
   output logic                      win_valid,
   input  logic                      win_ready,
`ifdef SOBEL_LB_CTRL_OVF_EN
   output logic                      ovf_err,
`endif
   output logic                      line_done
);

   localparam int CNT_W  = $clog2(LINE_W);
   localparam int FILL_W = $clog2(NUM_LB * LINE_W) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(LINE_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_LB * LINE_W);
   localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * LINE_W);

   lb_state_e             state;
   logic [CNT_W-1:0]      wr_cnt;
   logic [CNT_W-1:0]      rd_cnt;
   logic [LB_SEL_W-1:0]   wr_sel;
   logic [LB_SEL_W-1:0]   rd_sel;
   logic [FILL_W-1:0]     fill;
   logic                  accept;
   logic                  rd_beat;
   logic [NUM_LB-1:0]     rd_mask;
   logic [9*PIX_W-1:0]    win_next;

   // Ready only looks at the registered fill so a full ring never takes a pixel.
   assign pix_ready  = (fill < FILL_FULL);
   assign accept     = pix_valid && pix_ready;
   assign lb_wr_data = pix_data;
   assign rd_beat    = (state == RD_LINE) && (!win_valid || win_ready);

   sobel_lb_win_mux #(
      .NUM_LB (NUM_LB),
      .PIX_W  (PIX_W)
   ) u_win_mux (
      .lb_rd_data (lb_rd_data),
      .rd_sel     (rd_sel),
      .win_data   (win_next)
   );

   // Write strobe: only the buffer currently being filled, only on accept.
   always_comb begin
      lb_wr_en = '0;
      if (accept) begin
         lb_wr_en[wr_sel] = 1'b1;
      end else begin
         lb_wr_en = '0;
      end
   end

   // The three buffers holding the oldest complete lines, starting at rd_sel.
   always_comb begin
      rd_mask = '0;
      rd_mask[rd_sel] = 1'b1;
      rd_mask[lb_inc(rd_sel)] = 1'b1;
      rd_mask[lb_inc(lb_inc(rd_sel))] = 1'b1;
   end

   // Read pointers advance only on an actual beat so stalls never drop a window.
   always_comb begin
      if (rd_beat) begin
         lb_rd_en = rd_mask;
      end else begin
         lb_rd_en = '0;
      end
   end

   // Write position: pixel index within the line and the buffer being filled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt <= '0;
         wr_sel <= '0;
      end else if (accept) begin
         if (wr_cnt == CNT_LAST) begin
            wr_cnt <= '0;
            wr_sel <= lb_inc(wr_sel);
         end else begin
            wr_cnt <= wr_cnt + CNT_W'(1);
         end
      end
   end

   // Occupancy: pixels written minus windows read; a write and a beat cancel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill <= '0;
      end else begin
         case ({accept, rd_beat})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Read sequencer and output register: one line of beats, then back to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_cnt    <= '0;
         rd_sel    <= '0;
         win_valid <= 1'b0;
         win_data  <= '0;
         line_done <= 1'b0;
      end else begin
         line_done <= 1'b0;
         case (state)
            IDLE: begin
               if (fill >= FILL_START) begin
                  state <= RD_LINE;
               end else begin
                  state <= IDLE;
               end
            end
            RD_LINE: begin
               if (rd_beat && (rd_cnt == CNT_LAST)) begin
                  state     <= IDLE;
                  line_done <= 1'b1;
               end else begin
                  state <= RD_LINE;
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_beat) begin
            win_data  <= win_next;
            win_valid <= 1'b1;
            if (rd_cnt == CNT_LAST) begin
               rd_cnt <= '0;
               rd_sel <= lb_inc(rd_sel);
            end else begin
               rd_cnt <= rd_cnt + CNT_W'(1);
            end
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

`ifdef SOBEL_LB_CTRL_OVF_EN
   // Sticky record that a pixel was offered while the ring was full.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_err <= 1'b0;
      end else if (pix_valid && !pix_ready) begin
         ovf_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_lb_ctrl.sv
// tb_sobel_lb_ctrl: randomized bench with a pixel-history reference model and
// a behavioural model of the four line buffers beside the controller.
module tb_sobel_lb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = 8'h00;
   logic        pix_ready;
   logic [3:0]  lb_wr_en;
   logic [7:0]  lb_wr_data;
   logic [3:0]  lb_rd_en;
   logic [95:0] lb_rd_data;
   logic [71:0] win_data;
   logic        win_valid;
   logic        win_ready = 1'b0;
   logic        line_done;
`ifdef SOBEL_LB_CTRL_OVF_EN
   logic        ovf_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   sobel_lb_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .lb_wr_en   (lb_wr_en),
      .lb_wr_data (lb_wr_data),
      .lb_rd_en   (lb_rd_en),
      .lb_rd_data (lb_rd_data),
      .win_data   (win_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
`ifdef SOBEL_LB_CTRL_OVF_EN
      .ovf_err    (ovf_err),
`endif
      .line_done  (line_done)
   );

   always #5 clk = ~clk;

   // ---------------- line buffer environment ----------------
   logic [7:0] lb_mem [4][128];
   int         lb_wp [4];
   int         lb_rp [4];

   // Each buffer presents three pixels from its read pointer, edge-clamped.
   always @* begin
      lb_rd_data = '0;
      for (int b = 0; b < 4; b++) begin
         lb_rd_data[b*24 +: 24] = {lb_mem[b][lb_rp[b]],
                                   lb_mem[b][(lb_rp[b] + 1 > 127) ? 127 : lb_rp[b] + 1],
                                   lb_mem[b][(lb_rp[b] + 2 > 127) ? 127 : lb_rp[b] + 2]};
      end
   end

   // Buffer write/read pointer behaviour.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (!rst_n) begin
            lb_wp[b] <= 0;
            lb_rp[b] <= 0;
         end else begin
            if (lb_wr_en[b]) begin
               lb_mem[b][lb_wp[b]] <= lb_wr_data;
               lb_wp[b] <= (lb_wp[b] + 1) % 128;
            end
            if (lb_rd_en[b]) lb_rp[b] <= (lb_rp[b] + 1) % 128;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]  hist [8][128];   // pixel history by absolute line number mod 8
   int          m_acc = 0;       // pixels accepted since reset
   int          m_fill = 0;
   bit          m_rd = 1'b0;     // a line is being streamed
   int          m_rd_line = 0;   // absolute line number of the oldest line
   int          m_beat = 0;
   bit          m_wv = 1'b0;
   logic [71:0] m_wd = '0;
   bit          m_ld = 1'b0;
   bit          m_ovf = 1'b0;
   bit          mid_rst_arm = 1'b0;
   bit          mid_rst_hit = 1'b0;

   function automatic logic [71:0] exp_window(input int base, input int j);
      logic [71:0] w;
      int          idx;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) begin
            idx = (j + k > 127) ? 127 : j + k;
            w[71 - (r*24 + k*8) -: 8] = hist[(base + r) % 8][idx];
         end
      end
      return w;
   endfunction

   task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int pv, input int pr, input bit rst_req);
      bit         rst_now, e_ready, e_acc, e_beat, was_rd;
      logic [3:0] e_wr_en, e_rd_en, hole;
      int         old_fill;
      @(negedge clk);
      rst_now = rst_req;
      if (mid_rst_arm && m_rd && m_beat == 50) begin
         rst_now     = 1'b1;
         mid_rst_arm = 1'b0;
         mid_rst_hit = 1'b1;
      end
      rst_n     = !rst_now;
      pix_valid = ($urandom_range(99) < pv);
      pix_data  = 8'($urandom);
      win_ready = ($urandom_range(99) < pr);
      #1;
      e_ready = (m_fill < 512);
      e_acc   = pix_valid && e_ready;
      e_beat  = m_rd && (!m_wv || win_ready);
      e_wr_en = e_acc ? (4'b0001 << ((m_acc / 128) % 4)) : 4'b0000;
      hole    = 4'b0001 << ((m_rd_line + 3) % 4);
      e_rd_en = e_beat ? ~hole : 4'b0000;
      check_eq("pix_ready", {71'd0, pix_ready}, {71'd0, e_ready});
      check_eq("lb_wr_en", {68'd0, lb_wr_en}, {68'd0, e_wr_en});
      check_eq("lb_wr_data", {64'd0, lb_wr_data}, {64'd0, pix_data});
      check_eq("lb_rd_en", {68'd0, lb_rd_en}, {68'd0, e_rd_en});
      check_eq("win_valid", {71'd0, win_valid}, {71'd0, m_wv});
      check_eq("win_data", win_data, m_wd);
      check_eq("line_done", {71'd0, line_done}, {71'd0, m_ld});
`ifdef SOBEL_LB_CTRL_OVF_EN
      check_eq("ovf_err", {71'd0, ovf_err}, {71'd0, m_ovf});
`endif
      if (rst_now) begin
         m_acc = 0; m_fill = 0; m_rd = 1'b0; m_rd_line = 0; m_beat = 0;
         m_wv = 1'b0; m_wd = '0; m_ld = 1'b0; m_ovf = 1'b0;
      end else begin
         old_fill = m_fill;
         was_rd   = m_rd;
         if (pix_valid && !e_ready) m_ovf = 1'b1;
         if (e_acc) begin
            hist[(m_acc / 128) % 8][m_acc % 128] = pix_data;
            m_acc++;
         end
         m_fill = m_fill + int'(e_acc) - int'(e_beat);
         m_ld = 1'b0;
         if (e_beat) begin
            m_wd = exp_window(m_rd_line, m_beat);
            m_wv = 1'b1;
            if (m_beat == 127) begin
               m_beat = 0;
               m_rd_line++;
               m_rd = 1'b0;
               m_ld = 1'b1;
            end else begin
               m_beat++;
            end
         end else if (win_ready) begin
            m_wv = 1'b0;
         end
         if (!was_rd && old_fill >= 384) m_rd = 1'b1;
      end
   endtask

   task automatic run(input int n, input int pv, input int pr);
      for (int i = 0; i < n; i++) step(pv, pr, 1'b0);
   endtask

   initial begin
      // Reset state.
      step(0, 0, 1'b1);
      step(0, 0, 1'b1);
      // Three lines at full rate, then a continuous stream of several lines.
      run(1200, 100, 100);
      // Downstream stall mid-line: window held, no beats.
      run(10, 100, 0);
      run(300, 100, 100);
      // Random traffic with back-pressure.
      run(1500, 70, 60);
      // Reset in the middle of a line at beat 50.
      mid_rst_arm = 1'b1;
      for (int i = 0; i < 2000 && mid_rst_arm; i++) step(100, 100, 1'b0);
      check_eq("mid_rst_hit", {71'd0, mid_rst_hit}, 72'd1);
      run(20, 0, 100);
      // Fill to the limit with the consumer stalled; extra pixels are dropped.
      run(700, 100, 0);
      run(900, 100, 100);
      // Heavy back-pressure, random input.
      run(1500, 90, 30);
      run(400, 0, 100);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
